// File: rtl/uart_mem_loader_pkg.sv
// Shared types for the memory clients sitting upstream of request_handler.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package uart_mem_loader_pkg;

    // Which client currently owns the memory port.
    typedef enum logic [1:0] {
        CLIENT_NONE,
        CLIENT_UART,
        CLIENT_VGA
    } current_client_t;

    // VGA fetch engine states.
    typedef enum logic [1:0] {
        VGA_IDLE,
        VGA_FETCH,
        VGA_WAIT
    } VGA_state_t;

    // UART loader states.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } loader_state_t;

    // One buffered word: {sel, data}.
    localparam int WORD_ENTRY_W = 36;

    // Byte enables for a word holding 'cnt' packed bytes (cnt = 1..4).
    function automatic logic [3:0] sel_for_count(input logic [2:0] cnt);
        logic [3:0] r;
        r = 4'hF;
        if (cnt < 3'd4)
            r = (4'b0001 << cnt) - 4'b0001;
        return r;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO holding {sel,data} entries for the UART loader.
// Latency: 1 cycle push-to-visible, head is read combinationally.
// Backpressure: caller must not push when full unless popping the same cycle; clear empties it.
// Ports: clk/rst (async, active-high), i_clear, i_push/i_push_dat, i_pop, o_head_dat, o_full, o_empty.
module uart_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);

    // Storage is not reset: contents are only observed when count says they are valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Packs UART bytes little-endian into words and writes them sequentially to memory from BASE_ADDR.
// Latency: a completed word is requested 1 cycle after the byte that completes it (no bypass).
// Backpressure: requests held until UART_enable & ~mem_busy; words arriving with the FIFO full are dropped (rx_overflow).
// Ports: clk/rst, start/flush control, rx_data/rx_valid byte stream, UART_enable/mem_busy grant,
//        *_from_UART memory request, load_busy/load_done/rx_overflow/words_written status.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        UART_enable,
    input  logic        mem_busy,
    output logic        write_from_UART,
    output logic        read_from_UART,
    output logic [31:0] adr_from_UART,
    output logic [31:0] data_from_UART,
    output logic [3:0]  sel_from_UART,
    output logic        load_busy,
    output logic        load_done,
    output logic        rx_overflow,
    output logic [31:0] words_written
);
    loader_state_t r_state;
    logic [1:0]    r_idx;
    logic [23:0]   r_acc;          // bytes 0..2 of the word in progress, unused bytes kept 0
    logic [31:0]   r_offset;
    logic [31:0]   r_words;
    logic [31:0]   r_pushed;
    logic          r_overflow;
    logic          r_load_busy;
    logic          r_load_done;

    logic                    w_empty;
    logic                    w_full;
    logic [WORD_ENTRY_W-1:0] w_head;
    logic                    w_acc;
    logic                    w_in_load;
    logic                    w_room;
    logic                    w_byte_en;
    logic [2:0]              w_cnt;
    logic [31:0]             w_pack;
    logic                    w_push_word;
    logic                    w_fifo_push;
    logic                    w_drop;

    always_comb begin
        w_acc     = ~w_empty & UART_enable & ~mem_busy;
        w_in_load = (r_state == LOAD) & ~start;
        w_room    = (r_pushed < 32'(MAX_WORDS));
        w_byte_en = w_in_load & rx_valid & w_room;
        // The same-cycle byte is packed before any flush looks at the index.
        w_pack = {8'h00, r_acc};
        if (w_byte_en)
            w_pack[{r_idx, 3'b000} +: 8] = rx_data;
        w_cnt       = {1'b0, r_idx} + {2'b00, w_byte_en};
        w_push_word = w_in_load & w_room &
                      ((w_cnt == 3'd4) | (flush & (w_cnt != 3'd0)));
        // A full FIFO still takes the word if the head leaves this cycle.
        w_fifo_push = w_push_word & (~w_full | w_acc);
        w_drop      = w_push_word & w_full & ~w_acc;
    end

    uart_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (start),
        .i_push     (w_fifo_push),
        .i_push_dat ({sel_for_count(w_cnt), w_pack}),
        .i_pop      (w_acc),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_offset    <= '0;
            r_words     <= '0;
            r_pushed    <= '0;
            r_overflow  <= 1'b0;
            r_load_busy <= 1'b0;
            r_load_done <= 1'b0;
        end else if (start) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_acc       <= '0;
            r_offset    <= '0;
            r_words     <= '0;
            r_pushed    <= '0;
            r_overflow  <= 1'b0;
            r_load_busy <= 1'b1;
            r_load_done <= 1'b0;
        end else begin
            if (w_acc) begin
                r_offset <= r_offset + 32'd4;
                r_words  <= r_words + 32'd1;
            end
            if (w_fifo_push)
                r_pushed <= r_pushed + 32'd1;
            if (w_drop)
                r_overflow <= 1'b1;
            // Index wraps on every completed/flushed word, dropped or not.
            if (w_push_word) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (w_byte_en) begin
                r_idx <= r_idx + 2'd1;
                r_acc <= w_pack[23:0];
            end
            case (r_state)
                LOAD: begin
                    if (w_acc && (r_words + 32'd1 == 32'(MAX_WORDS))) begin
                        r_state     <= DONE;
                        r_load_busy <= 1'b0;
                        r_load_done <= 1'b1;
                    end else if (flush) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_empty) begin
                        r_state     <= DONE;
                        r_load_busy <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign write_from_UART = ~w_empty;
    assign read_from_UART  = 1'b0;
    assign adr_from_UART   = BASE_ADDR + r_offset;
    assign data_from_UART  = w_empty ? 32'h0 : w_head[31:0];
    assign sel_from_UART   = w_empty ? 4'h0  : w_head[35:32];
    assign load_busy       = r_load_busy;
    assign load_done       = r_load_done;
    assign rx_overflow     = r_overflow;
    assign words_written   = r_words;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: one default instance plus a MAX_WORDS=2 instance.
// Latency: n/a.
// Backpressure: driven directly through UART_enable/mem_busy.
module tb_uart_mem_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       UART_enable = 1'b0;
    logic       mem_busy = 1'b0;

    logic        write_from_UART, read_from_UART, load_busy, load_done, rx_overflow;
    logic [31:0] adr_from_UART, data_from_UART, words_written;
    logic [3:0]  sel_from_UART;

    logic        write_2, read_2, busy_2, done_2, ovf_2;
    logic [31:0] adr_2, data_2, words_2;
    logic [3:0]  sel_2;

    int checks   = 0;
    int failures = 0;
    int n2       = 0;
    logic [31:0] d2_last = 32'h0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_t;
    wr_t wq[$];

    uart_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .UART_enable(UART_enable), .mem_busy(mem_busy),
        .write_from_UART(write_from_UART), .read_from_UART(read_from_UART),
        .adr_from_UART(adr_from_UART), .data_from_UART(data_from_UART),
        .sel_from_UART(sel_from_UART), .load_busy(load_busy), .load_done(load_done),
        .rx_overflow(rx_overflow), .words_written(words_written)
    );

    uart_mem_loader #(.MAX_WORDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .flush(flush),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .UART_enable(UART_enable), .mem_busy(mem_busy),
        .write_from_UART(write_2), .read_from_UART(read_2),
        .adr_from_UART(adr_2), .data_from_UART(data_2),
        .sel_from_UART(sel_2), .load_busy(busy_2), .load_done(done_2),
        .rx_overflow(ovf_2), .words_written(words_2)
    );

    always #5 clk = ~clk;

    // Record accepted writes mid-cycle, where the coming edge will see the same values.
    always @(negedge clk) begin
        if (!rst && write_from_UART && UART_enable && !mem_busy)
            wq.push_back('{adr: adr_from_UART, data: data_from_UART, sel: sel_from_UART});
        if (!rst && write_2 && UART_enable && !mem_busy) begin
            n2++;
            d2_last = data_2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [31:0] adr,
                          input logic [31:0] data, input logic [3:0] sel);
        if (i < wq.size()) begin
            chk({tag, "_adr"},  wq[i].adr,  adr);
            chk({tag, "_data"}, wq[i].data, data);
            chk({tag, "_sel"},  {28'h0, wq[i].sel}, {28'h0, sel});
        end else begin
            chk({tag, "_present"}, 32'(wq.size()), 32'(i + 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_write", {31'h0, write_from_UART}, 32'h0);
        chk("rst_read",  {31'h0, read_from_UART},  32'h0);
        chk("rst_adr",   adr_from_UART,            32'h0);
        chk("rst_data",  data_from_UART,           32'h0);
        chk("rst_sel",   {28'h0, sel_from_UART},   32'h0);
        chk("rst_busy",  {31'h0, load_busy},       32'h0);
        chk("rst_done",  {31'h0, load_done},       32'h0);
        chk("rst_ovf",   {31'h0, rx_overflow},     32'h0);
        chk("rst_words", words_written,            32'h0);
        rst = 1'b0;
        tick();
        // Bytes in IDLE are ignored
        send_byte(8'h99);
        chk("idle_write", {31'h0, write_from_UART}, 32'h0);

        // 1: two words streamed with the grant held
        UART_enable = 1'b1;
        pulse_start();
        chk("t1_busy", {31'h0, load_busy}, 32'h1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        tick(); tick(); tick();
        chk("t1_count", 32'(wq.size()), 32'd2);
        chk_wr("t1_w0", 0, 32'h0, 32'h4433_2211, 4'hF);
        chk_wr("t1_w1", 1, 32'h4, 32'h8877_6655, 4'hF);
        chk("t1_words", words_written, 32'd2);
        chk("t1_adr", adr_from_UART, 32'h8);

        // 2: overflow while grant withheld
        UART_enable = 1'b0;
        wq.delete();
        pulse_start();
        for (int i = 0; i < 20; i++)
            send_byte(8'(i + 1));
        chk("t2_nowrite", 32'(wq.size()), 32'd0);
        chk("t2_pending", {31'h0, write_from_UART}, 32'h1);
        chk("t2_ovf", {31'h0, rx_overflow}, 32'h1);
        chk("t2_head", data_from_UART, 32'h0403_0201);
        UART_enable = 1'b1;
        for (int i = 0; i < 6; i++)
            tick();
        chk("t2_count", 32'(wq.size()), 32'd4);
        chk_wr("t2_w0", 0, 32'h0, 32'h0403_0201, 4'hF);
        chk_wr("t2_w1", 1, 32'h4, 32'h0807_0605, 4'hF);
        chk_wr("t2_w2", 2, 32'h8, 32'h0C0B_0A09, 4'hF);
        chk_wr("t2_w3", 3, 32'hC, 32'h100F_0E0D, 4'hF);
        chk("t2_words", words_written, 32'd4);

        // 3: partial word flush
        wq.delete();
        pulse_start();
        chk("t3_ovf_clr", {31'h0, rx_overflow}, 32'h0);
        chk("t3_words_clr", words_written, 32'h0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_write", {31'h0, write_from_UART}, 32'h1);
        chk("t3_data", data_from_UART, 32'h0000_BBAA);
        chk("t3_sel", {28'h0, sel_from_UART}, 32'h3);
        chk("t3_busy_flush", {31'h0, load_busy}, 32'h1);
        tick();
        chk("t3_drained", {31'h0, write_from_UART}, 32'h0);
        chk("t3_not_done_yet", {31'h0, load_done}, 32'h0);
        tick();
        chk("t3_done", {31'h0, load_done}, 32'h1);
        chk("t3_busy_off", {31'h0, load_busy}, 32'h0);
        chk_wr("t3_w0", 0, 32'h0, 32'h0000_BBAA, 4'b0011);

        // 3b: byte and flush in the same cycle
        wq.delete();
        pulse_start();
        send_byte(8'h01);
        rx_data  = 8'hCC;
        rx_valid = 1'b1;
        flush    = 1'b1;
        tick();
        rx_valid = 1'b0;
        flush    = 1'b0;
        for (int k = 0; k < 10 && !load_done; k++)
            tick();
        chk("t3b_done", {31'h0, load_done}, 32'h1);
        chk("t3b_count", 32'(wq.size()), 32'd1);
        chk_wr("t3b_w0", 0, 32'h0, 32'h0000_CC01, 4'b0011);

        // 4: MAX_WORDS=2 instance stops after two words
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 12; i++)
            send_byte(8'hA0 + 8'(i));
        tick(); tick();
        chk("t4_writes", 32'(n2), 32'd2);
        chk("t4_last", d2_last, 32'hA7A6_A5A4);
        chk("t4_done", {31'h0, done_2}, 32'h1);
        chk("t4_busy", {31'h0, busy_2}, 32'h0);
        chk("t4_words", words_2, 32'd2);
        chk("t4_idle_req", {31'h0, write_2}, 32'h0);

        // 5: request held across mem_busy
        wq.delete();
        mem_busy = 1'b1;
        pulse_start();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        for (int k = 0; k < 3; k++) begin
            chk("t5_held", {31'h0, write_from_UART}, 32'h1);
            chk("t5_adr", adr_from_UART, 32'h0);
            chk("t5_data", data_from_UART, 32'hEFBE_ADDE);
            tick();
        end
        mem_busy = 1'b0;
        tick(); tick();
        chk("t5_count", 32'(wq.size()), 32'd1);
        chk_wr("t5_w0", 0, 32'h0, 32'hEFBE_ADDE, 4'hF);
        chk("t5_words", words_written, 32'd1);

        // 6: restart mid-load with two words queued
        wq.delete();
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        UART_enable = 1'b0;
        for (int i = 0; i < 8; i++)
            send_byte(8'h50 + 8'(i));
        chk("t6_adr_before", adr_from_UART, 32'h4);
        chk("t6_words_before", words_written, 32'd1);
        chk("t6_pending", {31'h0, write_from_UART}, 32'h1);
        pulse_start();
        chk("t6_empty", {31'h0, write_from_UART}, 32'h0);
        chk("t6_adr", adr_from_UART, 32'h0);
        chk("t6_words", words_written, 32'h0);
        chk("t6_busy", {31'h0, load_busy}, 32'h1);
        chk("t6_data", data_from_UART, 32'h0);
        UART_enable = 1'b1;
        tick(); tick(); tick();
        chk("t6_count", 32'(wq.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
